// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer: convolution loop-nest step generator with stride, channel groups and same/valid padding
module conv_loop_sequencer #(
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int INPUT_NB_CHANNELS  = 4,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int KERNEL_SIZE        = 3,
    parameter int STRIDE             = 1,
    parameter int OUT_CH_PAR         = 8,
    localparam int XW  = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW  = $clog2(FEATURE_MAP_HEIGHT),
    localparam int OCW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
    localparam int IW  = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1,
    localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic                  pad_mode,
    output logic                  running,
    output logic                  done,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic [XW-1:0]         out_x,
    output logic [YW-1:0]         out_y,
    output logic [OCW-1:0]        och_base,
    output logic [IW-1:0]         ich,
    output logic [KW-1:0]         kx,
    output logic [KW-1:0]         ky,
    output logic signed [XW+1:0]  in_x,
    output logic signed [YW+1:0]  in_y,
    output logic                  pad_flag,
    output logic                  first,
    output logic                  last
);
    localparam int W = FEATURE_MAP_WIDTH;
    localparam int H = FEATURE_MAP_HEIGHT;
    localparam int K = KERNEL_SIZE;
    localparam int S = STRIDE;
    localparam int PAD_SAME = (K - 1) / 2;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    localparam logic [XW-1:0] OXM_SAME = XW'((W + S - 1) / S - 1), OXM_VALID = XW'((W - K) / S);
    localparam logic [YW-1:0] OYM_SAME = YW'((H + S - 1) / S - 1), OYM_VALID = YW'((H - K) / S);
    localparam logic [KW-1:0] KM = KW'(K - 1);
    localparam logic [IW-1:0] IM = IW'(INPUT_NB_CHANNELS - 1);
    localparam logic [OCW-1:0] OCM = OCW'(OUTPUT_NB_CHANNELS - OUT_CH_PAR);
    localparam logic [OCW-1:0] OCSTEP = OCW'(OUT_CH_PAR);

    logic [1:0] st_q, st_d;
    logic mode_q, mode_d, run_d, adv;
    logic c_i, c_kx, c_ky, c_o, c_x, c_y;
    logic [XW-1:0] ox_q, ox_d, oxm;
    logic [YW-1:0] oy_q, oy_d, oym;
    logic [OCW-1:0] och_q, och_d;
    logic [IW-1:0] ich_q, ich_d;
    logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic running_q, done_q, valid_q, pf_q, pf_d, first_q, first_d, last_q, last_d;
    logic signed [XW+1:0] ix_q, ix_d;
    logic signed [YW+1:0] iy_q, iy_d;
    int pad, ix, iy;

    // Next counters follow the carry chain; derived fields are computed for the counters about to be presented
    always_comb begin
        mode_d = (st_q == S_IDLE && start) ? pad_mode : mode_q;
        oxm    = mode_q ? OXM_VALID : OXM_SAME;
        oym    = mode_q ? OYM_VALID : OYM_SAME;
        adv    = st_q == S_RUN && step_ready;
        c_i    = adv && ich_q == IM;
        c_kx   = c_i && kx_q == KM;
        c_ky   = c_kx && ky_q == KM;
        c_o    = c_ky && och_q == OCM;
        c_x    = c_o && ox_q == oxm;
        c_y    = c_x && oy_q == oym;
        st_d   = st_q == S_IDLE ? (start ? S_RUN : S_IDLE) :
                 st_q == S_RUN  ? (c_y ? S_DONE : S_RUN) : S_IDLE;
        run_d  = st_d == S_RUN;
        ich_d  = !run_d ? '0 : adv  ? (c_i  ? '0 : ich_q + 1'b1)  : ich_q;
        kx_d   = !run_d ? '0 : c_i  ? (c_kx ? '0 : kx_q + 1'b1)   : kx_q;
        ky_d   = !run_d ? '0 : c_kx ? (c_ky ? '0 : ky_q + 1'b1)   : ky_q;
        och_d  = !run_d ? '0 : c_ky ? (c_o  ? '0 : och_q + OCSTEP) : och_q;
        ox_d   = !run_d ? '0 : c_o  ? (c_x  ? '0 : ox_q + 1'b1)   : ox_q;
        oy_d   = !run_d ? '0 : c_x  ? (c_y  ? '0 : oy_q + 1'b1)   : oy_q;
        pad    = mode_d ? 0 : PAD_SAME;
        ix     = int'(ox_d) * S + int'(kx_d) - pad;
        iy     = int'(oy_d) * S + int'(ky_d) - pad;
        ix_d   = run_d ? (XW+2)'(ix) : '0;
        iy_d   = run_d ? (YW+2)'(iy) : '0;
        pf_d   = run_d && (ix < 0 || ix > W - 1 || iy < 0 || iy > H - 1);
        first_d = run_d && ky_d == '0 && kx_d == '0 && ich_d == '0;
        last_d  = run_d && ky_d == KM && kx_d == KM && ich_d == IM;
    end

    // State, counters and every output field are registered; reset wins over start
    always_ff @(posedge clk) begin
        if (rst_in) begin
            st_q      <= S_IDLE;
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            och_q     <= '0;
            ich_q     <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            ix_q      <= '0;
            iy_q      <= '0;
            pf_q      <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            mode_q    <= mode_d;
            running_q <= run_d;
            done_q    <= st_d == S_DONE;
            valid_q   <= run_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            och_q     <= och_d;
            ich_q     <= ich_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
            pf_q      <= pf_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign step_valid = valid_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign och_base   = och_q;
    assign ich        = ich_q;
    assign kx         = kx_q;
    assign ky         = ky_q;
    assign in_x       = ix_q;
    assign in_y       = iy_q;
    assign pad_flag   = pf_q;
    assign first      = first_q;
    assign last       = last_q;
endmodule
